// File: rtl/fp_mat_dma.sv
// Matrix DMA between SDRAM (Avalon-MM master) and local matrix RAM.
// LOAD streams N*N words in with bounded outstanding reads; STORE writes RAM back out.
module fp_mat_dma #(
  parameter int unsigned ADDR_W          = 24,
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned RAM_AW          = 10,
  parameter int unsigned MAX_DIM         = 32,
  parameter int unsigned DEFAULT_DIM     = 16,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       dataa,
  input  logic [31:0]       datab,
  output logic              done,
  output logic [31:0]       result,
  output logic [ADDR_W-1:0] address,
  output logic              read,
  output logic              write,
  output logic [DATA_W-1:0] writedata,
  input  logic [DATA_W-1:0] readdata,
  input  logic              readdatavalid,
  input  logic              waitrequest,
  output logic [RAM_AW-1:0] ram_wraddress,
  output logic [RAM_AW-1:0] ram_rdaddress,
  output logic [DATA_W-1:0] ram_wrdata,
  output logic              ram_wren,
  output logic              ram_rden,
  input  logic [DATA_W-1:0] ram_q,
  output logic              eng_start,
  input  logic              eng_done,
  input  logic              status_read,
  output logic [31:0]       status_readdata,
  output logic              irq
);

  localparam int unsigned STRIDE_SH = $clog2(DATA_W / 8);
  localparam int unsigned RAM_WORDS = 1 << RAM_AW;
  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'((1 << STRIDE_SH) - 1);
  localparam logic [7:0] MAX_OUT = 8'(MAX_OUTSTANDING);
  localparam logic [7:0] DEF_N   = 8'(DEFAULT_DIM);

  typedef enum logic [2:0] {
    IDLE, LOAD, ENGINE, STORE_FETCH, STORE_WRITE, WAIT_ACK
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   base_q;
  logic [15:0]         total_q;
  logic [15:0]         issued_q;
  logic [7:0]          outst_q;
  logic [15:0]         cnt_q;
  logic                mode_q;
  logic                irq_q;
  logic                done_q;
  logic [31:0]         result_q;
  logic                read_q;
  logic                write_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                wfirst_q;
  logic                ram_wren_q;
  logic [RAM_AW-1:0]   ram_wraddr_q;
  logic [DATA_W-1:0]   ram_wrdata_q;
  logic                ram_rden_q;
  logic [RAM_AW-1:0]   ram_rdaddr_q;
  logic                eng_start_q;
  logic [31:0]         status_q;

  logic [7:0]          n_sel;
  logic [15:0]         sq;
  logic                dim_bad;
  logic [ADDR_W-1:0]   base_in;
  logic                accept;
  logic [15:0]         issued_d;
  logic [7:0]          outst_d;
  logic [15:0]         cnt_d;
  logic                unused_bits;

  function automatic logic [ADDR_W-1:0] offs(input logic [15:0] k);
    return ADDR_W'(k) << STRIDE_SH;
  endfunction

  always_comb begin
    n_sel    = (datab[7:0] == 8'd0) ? DEF_N : datab[7:0];
    sq       = 16'(n_sel) * 16'(n_sel);
    dim_bad  = ({24'd0, n_sel} > MAX_DIM) || ({16'd0, sq} > RAM_WORDS);
    base_in  = dataa[ADDR_W-1:0] & ~LOW_MASK;
    accept   = read_q & ~waitrequest;
    issued_d = issued_q + 16'(accept);
    outst_d  = outst_q + 8'(accept) - 8'(readdatavalid);
    cnt_d    = cnt_q + 16'd1;
  end

  assign unused_bits = ^{dataa[31:ADDR_W], datab[31:9]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      base_q       <= '0;
      total_q      <= '0;
      issued_q     <= '0;
      outst_q      <= '0;
      cnt_q        <= '0;
      mode_q       <= 1'b0;
      irq_q        <= 1'b0;
      done_q       <= 1'b0;
      result_q     <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wfirst_q     <= 1'b0;
      ram_wren_q   <= 1'b0;
      ram_wraddr_q <= '0;
      ram_wrdata_q <= '0;
      ram_rden_q   <= 1'b0;
      ram_rdaddr_q <= '0;
      eng_start_q  <= 1'b0;
      status_q     <= '0;
    end else begin
      done_q      <= start;
      result_q    <= '0;
      eng_start_q <= 1'b0;
      ram_wren_q  <= 1'b0;
      ram_rden_q  <= 1'b0;
      if (status_read) status_q <= {irq_q, mode_q, 14'd0, cnt_q};
      if (start && state_q != IDLE) result_q <= 32'd1;

      unique case (state_q)
        IDLE: begin
          if (start) begin
            if (dim_bad) begin
              result_q <= 32'd2;
            end else begin
              base_q   <= base_in;
              total_q  <= sq;
              mode_q   <= datab[8];
              cnt_q    <= '0;
              issued_q <= '0;
              outst_q  <= '0;
              if (datab[8]) begin
                state_q      <= STORE_FETCH;
                ram_rden_q   <= 1'b1;
                ram_rdaddr_q <= '0;
              end else begin
                state_q <= LOAD;
                read_q  <= 1'b1;
                addr_q  <= base_in;
              end
            end
          end
        end

        LOAD: begin
          issued_q <= issued_d;
          outst_q  <= outst_d;
          if (accept) addr_q <= base_q + offs(issued_d);
          read_q <= (issued_d < total_q) && (outst_d < MAX_OUT);
          if (readdatavalid) begin
            ram_wren_q   <= 1'b1;
            ram_wraddr_q <= RAM_AW'(cnt_q);
            ram_wrdata_q <= readdata;
            cnt_q        <= cnt_d;
          end else if (cnt_q == total_q) begin
            // last RAM write is on the bus this cycle, so the engine may start next
            eng_start_q <= 1'b1;
            state_q     <= ENGINE;
            addr_q      <= '0;
          end
        end

        ENGINE: begin
          if (eng_done) begin
            irq_q   <= 1'b1;
            state_q <= WAIT_ACK;
          end
        end

        STORE_FETCH: begin
          write_q  <= 1'b1;
          addr_q   <= base_q + offs(cnt_q);
          wfirst_q <= 1'b1;
          state_q  <= STORE_WRITE;
        end

        STORE_WRITE: begin
          // RAM data is presented directly on the first write cycle, then held locally
          wfirst_q <= 1'b0;
          if (wfirst_q) wdata_q <= ram_q;
          if (!waitrequest) begin
            write_q <= 1'b0;
            cnt_q   <= cnt_d;
            if (cnt_d == total_q) begin
              irq_q   <= 1'b1;
              state_q <= WAIT_ACK;
              addr_q  <= '0;
              wdata_q <= '0;
            end else begin
              state_q      <= STORE_FETCH;
              ram_rden_q   <= 1'b1;
              ram_rdaddr_q <= RAM_AW'(cnt_d);
            end
          end
        end

        WAIT_ACK: begin
          if (status_read) begin
            irq_q   <= 1'b0;
            state_q <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign done            = done_q;
  assign result          = result_q;
  assign address         = addr_q;
  assign read            = read_q;
  assign write           = write_q;
  assign writedata       = wfirst_q ? ram_q : wdata_q;
  assign ram_wraddress   = ram_wraddr_q;
  assign ram_rdaddress   = ram_rdaddr_q;
  assign ram_wrdata      = ram_wrdata_q;
  assign ram_wren        = ram_wren_q;
  assign ram_rden        = ram_rden_q;
  assign eng_start       = eng_start_q;
  assign status_readdata = status_q;
  assign irq             = irq_q;

endmodule

// File: tb/tb_fp_mat_dma.sv
// Directed bench for fp_mat_dma with an Avalon memory responder and a RAM model.
module tb_fp_mat_dma;
  localparam int ADDR_W = 24;
  localparam int DATA_W = 32;
  localparam int RAM_AW = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, start, eng_done, status_read;
  logic [31:0]       dataa, datab;
  logic              done, read, write, ram_wren, ram_rden, eng_start, irq;
  logic [31:0]       result, status_readdata;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] writedata, ram_wrdata;
  logic [RAM_AW-1:0] ram_wraddress, ram_rdaddress;
  logic [DATA_W-1:0] readdata = '0;
  logic              readdatavalid = 1'b0;
  logic              waitrequest = 1'b0;
  logic [DATA_W-1:0] ram_q = '0;

  fp_mat_dma #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RAM_AW(RAM_AW),
    .MAX_DIM(32), .DEFAULT_DIM(16), .MAX_OUTSTANDING(8)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .dataa(dataa), .datab(datab),
    .done(done), .result(result), .address(address), .read(read), .write(write),
    .writedata(writedata), .readdata(readdata), .readdatavalid(readdatavalid),
    .waitrequest(waitrequest), .ram_wraddress(ram_wraddress),
    .ram_rdaddress(ram_rdaddress), .ram_wrdata(ram_wrdata), .ram_wren(ram_wren),
    .ram_rden(ram_rden), .ram_q(ram_q), .eng_start(eng_start), .eng_done(eng_done),
    .status_read(status_read), .status_readdata(status_readdata), .irq(irq)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] memword(input logic [ADDR_W-1:0] a);
    return 32'hA500_0000 | 32'(a);
  endfunction

  // responder / RAM model state
  logic [DATA_W-1:0] ram_mem [0:1023];
  int cyc = 0, acc_cnt = 0, wren_cnt = 0, eng_cnt = 0, stab_err = 0;
  int outst_tb = 0, max_out = 0, last_rdv_cyc = 0, eng_cyc = 0, start_cyc = 0, first_rd_cyc = -1;
  logic hold = 1'b0, wr_rand = 1'b0;
  logic [ADDR_W-1:0] rd_log[$];
  logic [ADDR_W-1:0] wr_addr_log[$];
  logic [31:0]       wr_data_log[$];
  logic [31:0]       pend_data[$];
  int                pend_due[$];
  logic              prev_rw = 1'b0, prev_ww = 1'b0;
  logic [ADDR_W-1:0] prev_a = '0;
  logic [31:0]       prev_d = '0;

  always @(posedge clk) begin
    cyc++;
    if (prev_rw && (!read || address != prev_a)) stab_err++;
    if (prev_ww && (!write || address != prev_a || writedata != prev_d)) stab_err++;
    prev_rw = read && waitrequest;
    prev_ww = write && waitrequest;
    prev_a  = address;
    prev_d  = writedata;
    if (read && first_rd_cyc < 0) first_rd_cyc = cyc;
    if (read && !waitrequest) begin
      acc_cnt++;
      rd_log.push_back(address);
      pend_data.push_back(memword(address));
      pend_due.push_back(cyc + 2);
    end
    if (write && !waitrequest) begin
      wr_addr_log.push_back(address);
      wr_data_log.push_back(writedata);
    end
    outst_tb = outst_tb + int'(read && !waitrequest) - int'(readdatavalid);
    if (outst_tb > max_out) max_out = outst_tb;
    if (readdatavalid) last_rdv_cyc = cyc;
    if (eng_start) begin eng_cnt++; eng_cyc = cyc; end
    if (start) start_cyc = cyc;

    readdatavalid <= 1'b0;
    if (!hold && pend_due.size() > 0 && pend_due[0] <= cyc) begin
      readdatavalid <= 1'b1;
      readdata      <= pend_data.pop_front();
      void'(pend_due.pop_front());
    end
    waitrequest <= wr_rand ? 1'($urandom_range(0, 1)) : 1'b0;

    if (ram_wren) begin ram_mem[ram_wraddress] <= ram_wrdata; wren_cnt++; end
    if (ram_rden) ram_q <= ram_mem[ram_rdaddress];
  end

  task automatic clear_logs();
    acc_cnt = 0; wren_cnt = 0; eng_cnt = 0; stab_err = 0;
    outst_tb = 0; max_out = 0; first_rd_cyc = -1;
    rd_log.delete(); wr_addr_log.delete(); wr_data_log.delete();
  endtask

  task automatic do_start(input logic [31:0] a, input logic [31:0] b,
                          output logic dn, output logic [31:0] res);
    start = 1'b1; dataa = a; datab = b;
    @(negedge clk);
    start = 1'b0;
    dn  = done;
    res = result;
  endtask

  task automatic wait_eng(input int budget);
    for (int i = 0; i < budget && eng_cnt == 0; i++) @(negedge clk);
    check("eng_start seen", 64'(eng_cnt != 0), 64'd1);
  endtask

  task automatic finish_engine();
    eng_done = 1'b1;
    @(negedge clk);
    eng_done = 1'b0;
    check("irq after eng_done", 64'(irq), 64'd1);
  endtask

  task automatic status_ack(input logic [31:0] exp);
    status_read = 1'b1;
    @(negedge clk);
    status_read = 1'b0;
    check("status word", 64'(status_readdata), 64'(exp));
    check("irq cleared", 64'(irq), 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  logic        dn;
  logic [31:0] res;
  int          w;

  initial begin
    reset = 1'b1; start = 1'b0; dataa = '0; datab = '0; eng_done = 1'b0; status_read = 1'b0;
    repeat (3) @(negedge clk);
    check("reset strobes", 64'({done, read, write, ram_wren, ram_rden, eng_start, irq}), 64'd0);
    check("reset address", 64'(address), 64'd0);
    check("reset result", 64'(result), 64'd0);
    check("reset status", 64'(status_readdata), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // LOAD N=2
    clear_logs();
    do_start(32'h0000_0100, 32'd2, dn, res);
    check("t1 done", 64'(dn), 64'd1);
    check("t1 result", 64'(res), 64'd0);
    @(negedge clk);
    check("t1 done drops", 64'({done, result}), 64'd0);
    check("t1 first read latency", 64'(first_rd_cyc - start_cyc), 64'd1);
    wait_eng(50);
    check("t1 reads", 64'(rd_log.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < rd_log.size()) check("t1 read addr", 64'(rd_log[i]), 64'(32'h100 + 4 * i));
      check("t1 ram word", 64'(ram_mem[i]), 64'(memword(ADDR_W'(32'h100 + 4 * i))));
    end
    check("t1 ram writes", 64'(wren_cnt), 64'd4);
    check("t1 eng_start delay", 64'(eng_cyc - last_rdv_cyc), 64'd2);
    finish_engine();
    check("t1 eng_start pulses", 64'(eng_cnt), 64'd1);
    status_ack(32'h8000_0004);

    // LOAD N=4 with data withheld, plus start while busy
    clear_logs();
    hold = 1'b1;
    do_start(32'h0000_0400, 32'd4, dn, res);
    check("t2 result", 64'(res), 64'd0);
    repeat (20) @(negedge clk);
    check("t2 accepted at limit", 64'(acc_cnt), 64'd8);
    check("t2 read idle at limit", 64'(read), 64'd0);
    check("t2 max outstanding", 64'(max_out), 64'd8);
    do_start(32'h0, 32'd2, dn, res);
    check("t2 busy done", 64'(dn), 64'd1);
    check("t2 busy result", 64'(res), 64'd1);
    @(negedge clk);
    check("t2 busy result drops", 64'(result), 64'd0);
    hold = 1'b0;
    wait_eng(100);
    check("t2 accepted total", 64'(acc_cnt), 64'd16);
    check("t2 ram writes", 64'(wren_cnt), 64'd16);
    if (rd_log.size() > 8) check("t2 read 8 addr", 64'(rd_log[8]), 64'h420);
    check("t2 ram last", 64'(ram_mem[15]), 64'(memword(24'h43C)));
    finish_engine();
    status_ack(32'h8000_0010);

    // STORE N=3 with random waitrequest
    clear_logs();
    wr_rand = 1'b1;
    do_start(32'h0000_0200, 32'h0000_0103, dn, res);
    check("t3 result", 64'(res), 64'd0);
    for (int i = 0; i < 300 && !irq; i++) @(negedge clk);
    wr_rand = 1'b0;
    check("t3 irq", 64'(irq), 64'd1);
    check("t3 writes", 64'(wr_addr_log.size()), 64'd9);
    for (int i = 0; i < 9 && i < wr_addr_log.size(); i++)
      check("t3 write addr/data", {8'd0, wr_addr_log[i], wr_data_log[i]},
            {8'd0, 24'(32'h200 + 4 * i), memword(ADDR_W'(32'h400 + 4 * i))});
    check("t3 bus stability", 64'(stab_err), 64'd0);
    status_ack(32'hC000_0009);

    // oversize N
    clear_logs();
    do_start(32'h0, 32'd33, dn, res);
    check("t4 result", 64'(res), 64'd2);
    repeat (5) @(negedge clk);
    check("t4 no bus activity", 64'(acc_cnt + wr_addr_log.size()), 64'd0);
    check("t4 strobes idle", 64'({read, write, ram_wren, ram_rden}), 64'd0);

    // reset mid-LOAD
    clear_logs();
    do_start(32'h0000_0800, 32'd4, dn, res);
    check("t5 result", 64'(res), 64'd0);
    for (int i = 0; i < 100 && wren_cnt < 5; i++) @(negedge clk);
    check("t5 five words in", 64'(wren_cnt >= 5), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    check("t5 strobes zero", 64'({done, read, write, ram_wren, ram_rden, eng_start, irq}), 64'd0);
    check("t5 address zero", 64'(address), 64'd0);
    check("t5 ram addr zero", 64'({ram_wraddress, ram_rdaddress}), 64'd0);
    reset = 1'b0;
    w = wren_cnt;
    repeat (15) @(negedge clk);
    check("t5 stray data ignored", 64'(wren_cnt), 64'(w));

    // default N=16
    clear_logs();
    do_start(32'h0000_1000, 32'd0, dn, res);
    check("t6 result", 64'(res), 64'd0);
    wait_eng(1500);
    check("t6 accepted", 64'(acc_cnt), 64'd256);
    if (rd_log.size() == 256) check("t6 last addr", 64'(rd_log[255]), 64'h13FC);
    check("t6 ram writes", 64'(wren_cnt), 64'd256);
    finish_engine();
    status_ack(32'h8000_0100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
